// File: rtl/ln_pkg.sv
// Shared definitions for the ln(y) range-reduction front end: class codes,
// float constants, pipeline latency and input classification.
package ln_pkg;

    localparam int LN_RR_LAT = 4;

    typedef enum logic [2:0] {
        CLS_NORMAL = 3'd0,
        CLS_ZERO   = 3'd1,
        CLS_NEG    = 3'd2,
        CLS_INF    = 3'd3,
        CLS_NAN    = 3'd4
    } ln_cls_e;

    localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
    localparam logic [31:0] FP_ONE      = 32'h3F80_0000;
    localparam logic [31:0] FP_ONE_HALF = 32'h3F00_0000;
    localparam logic [31:0] FP_TWO      = 32'h4000_0000;
    localparam logic [7:0]  FP_BIAS     = 8'd127;

    // A flushed subnormal counts as zero before the sign test, so -denorm
    // lands in the zero class rather than negative.
    function automatic ln_cls_e ln_classify(input logic [31:0] y, input bit flush);
        logic [7:0]  e;
        logic [22:0] f;
        logic        zero_like;
        e         = y[30:23];
        f         = y[22:0];
        zero_like = (e == 8'd0) && ((f == 23'd0) || flush);
        if (e == 8'hFF && f != 23'd0)  return CLS_NAN;
        else if (y[31] && !zero_like)  return CLS_NEG;
        else if (e == 8'hFF)           return CLS_INF;
        else if (zero_like)            return CLS_ZERO;
        else                           return CLS_NORMAL;
    endfunction

endpackage

// File: rtl/ln_range_reduce_if.sv
// Sample-in / reduced-argument-out bundle between the ln front end and its neighbours.
interface ln_range_reduce_if;
    logic [31:0]       y;
    logic              in_valid;
    logic              clr_err;
    logic [31:0]       x_out;
    logic              start_out;
    logic signed [8:0] k_out;
    logic [2:0]        cls_out;
    logic              err_sticky;

    modport master (
        output y, in_valid, clr_err,
        input  x_out, start_out, k_out, cls_out, err_sticky
    );

    modport slave (
        input  y, in_valid, clr_err,
        output x_out, start_out, k_out, cls_out, err_sticky
    );
endinterface

// File: rtl/ln_range_reduce_lzc24.sv
// 24-bit leading-zero counter; an all-zero input yields 24.
module lzc24 (
    input  logic [23:0] a,
    output logic [4:0]  cnt
);
    always_comb begin
        cnt = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (a[i]) cnt = 5'(23 - i);
        end
    end
endmodule

// File: rtl/ln_range_reduce.sv
// Splits y into 2^k * (1 + x) with |x| <= 0.5 for the downstream ln series core.
// Four registered stages: classify, reduce, LZC, normalise/pack.
module ln_range_reduce
    import ln_pkg::*;
#(
    parameter bit FLUSH_DENORM = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    ln_range_reduce_if.slave io
);

    logic [LN_RR_LAT:1] vld_q, vld_d;

    ln_cls_e     s1_cls_q, s1_cls_d;
    logic [7:0]  s1_exp_q, s1_exp_d;
    logic [22:0] s1_frac_q, s1_frac_d;

    ln_cls_e           s2_cls_q, s2_cls_d;
    logic [23:0]       s2_mag_q, s2_mag_d;
    logic              s2_neg_q, s2_neg_d;
    logic signed [8:0] s2_k_q, s2_k_d;

    ln_cls_e           s3_cls_q;
    logic [23:0]       s3_mag_q;
    logic              s3_neg_q;
    logic signed [8:0] s3_k_q;
    logic [4:0]        s3_lz_q, s3_lz_d;

    logic [31:0]       x_q, x_d;
    logic signed [8:0] k_q, k_d;
    ln_cls_e           cls_q, cls_d;
    logic              err_q, err_d;

    always_comb begin
        vld_d     = {vld_q[LN_RR_LAT-1:1], io.in_valid};
        s1_cls_d  = ln_classify(io.y, FLUSH_DENORM);
        s1_exp_d  = io.y[30:23];
        s1_frac_d = io.y[22:0];
    end

    // m >= 1.5 is folded to m/2 with k+1 so x stays in [-0.25, 0.5).
    always_comb begin
        s2_cls_d = s1_cls_q;
        s2_mag_d = 24'd0;
        s2_neg_d = 1'b0;
        s2_k_d   = 9'sd0;
        if (s1_cls_q == CLS_NORMAL) begin
            if (!s1_frac_q[22]) begin
                s2_mag_d = {1'b0, s1_frac_q};
                s2_k_d   = $signed({1'b0, s1_exp_q}) - 9'sd127;
            end else begin
                s2_neg_d = 1'b1;
                s2_mag_d = 24'h80_0000 - {1'b0, s1_frac_q};
                s2_k_d   = $signed({1'b0, s1_exp_q}) - 9'sd126;
            end
        end
    end

    lzc24 u_lzc (
        .a   (s2_mag_q),
        .cnt (s3_lz_d)
    );

    // Magnitude LSB weighs 2^-23 (or 2^-24 when negated), so the exponent is
    // 127 - lz, one lower for the negated branch.
    always_comb begin
        x_d   = FP_ZERO;
        k_d   = 9'sd0;
        cls_d = CLS_NORMAL;
        if (vld_q[LN_RR_LAT-1]) begin
            cls_d = s3_cls_q;
            k_d   = s3_k_q;
            if (s3_mag_q != 24'd0)
                x_d = {s3_neg_q,
                       FP_BIAS - {3'b0, s3_lz_q} - {7'b0, s3_neg_q},
                       23'(s3_mag_q << s3_lz_q)};
        end
    end

    // A result is set into the sticky flag as it leaves the output register,
    // which lets a same-cycle clear lose against it.
    always_comb begin
        err_d = err_q;
        if (io.clr_err) err_d = 1'b0;
        if (vld_q[LN_RR_LAT] && cls_q != CLS_NORMAL) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q     <= '0;
            s1_cls_q  <= CLS_NORMAL;
            s1_exp_q  <= '0;
            s1_frac_q <= '0;
            s2_cls_q  <= CLS_NORMAL;
            s2_mag_q  <= '0;
            s2_neg_q  <= 1'b0;
            s2_k_q    <= '0;
            s3_cls_q  <= CLS_NORMAL;
            s3_mag_q  <= '0;
            s3_neg_q  <= 1'b0;
            s3_k_q    <= '0;
            s3_lz_q   <= '0;
            x_q       <= '0;
            k_q       <= '0;
            cls_q     <= CLS_NORMAL;
            err_q     <= 1'b0;
        end else begin
            vld_q     <= vld_d;
            s1_cls_q  <= s1_cls_d;
            s1_exp_q  <= s1_exp_d;
            s1_frac_q <= s1_frac_d;
            s2_cls_q  <= s2_cls_d;
            s2_mag_q  <= s2_mag_d;
            s2_neg_q  <= s2_neg_d;
            s2_k_q    <= s2_k_d;
            s3_cls_q  <= s2_cls_q;
            s3_mag_q  <= s2_mag_q;
            s3_neg_q  <= s2_neg_q;
            s3_k_q    <= s2_k_q;
            s3_lz_q   <= s3_lz_d;
            x_q       <= x_d;
            k_q       <= k_d;
            cls_q     <= cls_d;
            err_q     <= err_d;
        end
    end

    assign io.x_out      = x_q;
    assign io.k_out      = k_q;
    assign io.cls_out    = cls_q;
    assign io.start_out  = vld_q[LN_RR_LAT];
    assign io.err_sticky = err_q;

endmodule

// File: tb/tb_ln_range_reduce.sv
// Scoreboard bench for ln_range_reduce: a real-arithmetic model predicts each
// result at issue time; a negedge monitor pops and compares emerging results.
module tb_ln_range_reduce;
    import ln_pkg::*;

    localparam bit FLUSH = 1'b1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ln_range_reduce_if io ();

    ln_range_reduce #(.FLUSH_DENORM(FLUSH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    typedef struct {
        logic [31:0]       y;
        logic [31:0]       x;
        logic signed [8:0] k;
        logic [2:0]        cls;
        int                issue;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic real sp2real(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:0] == 31'd0) return 0.0;
        d = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real2sp(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    function automatic real pow2(input int n);
        real p = 1.0;
        if (n >= 0) repeat (n) p = p * 2.0;
        else        repeat (-n) p = p / 2.0;
        return p;
    endfunction

    function automatic exp_t model(input logic [31:0] v);
        exp_t        e;
        int          ex;
        logic [22:0] f;
        bit          zl;
        real         m, xr;
        ex = int'(v[30:23]);
        f  = v[22:0];
        zl = (ex == 0) && ((f == 0) || FLUSH);
        e.y = v; e.x = 32'd0; e.k = 9'sd0; e.issue = 0;
        if (ex == 255 && f != 0)  e.cls = 3'd4;
        else if (v[31] && !zl)    e.cls = 3'd2;
        else if (ex == 255)       e.cls = 3'd3;
        else if (zl)              e.cls = 3'd1;
        else begin
            e.cls = 3'd0;
            m = sp2real({1'b0, 8'd127, f});
            if (f[22]) begin e.k = 9'(ex - 126); xr = m / 2.0 - 1.0; end
            else       begin e.k = 9'(ex - 127); xr = m - 1.0;       end
            e.x = real2sp(xr);
        end
        return e;
    endfunction

    // Monitor: one result per start_out pulse, idle outputs must read zero.
    always @(negedge clk) begin
        exp_t e;
        real  recon;
        if (rst_n) begin
            if (io.start_out) begin
                if (sb.size() == 0) chk("unexpected_start", 64'(io.start_out), 64'd0);
                else begin
                    e = sb.pop_front();
                    chk("x_out",   64'(io.x_out),   64'(e.x));
                    chk("k_out",   64'(io.k_out),   64'(e.k));
                    chk("cls_out", 64'(io.cls_out), 64'(e.cls));
                    chk("latency", 64'(cyc - e.issue), 64'd4);
                    if (e.cls == 3'd0) begin
                        recon = pow2(int'(io.k_out)) * (1.0 + sp2real(io.x_out));
                        chk("identity", $realtobits(recon), $realtobits(sp2real(e.y)));
                    end
                end
            end else begin
                chk("idle_zero", {23'd0, io.x_out, io.k_out, io.cls_out}, 64'd0);
            end
        end
    end

    task automatic send(input logic [31:0] v);
        exp_t e;
        io.y = v;
        io.in_valid = 1'b1;
        e = model(v);
        e.issue = cyc;
        sb.push_back(e);
        @(posedge clk); #1;
        io.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        io.in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() > 0; i++) idle(1);
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        io.y = 32'd0; io.in_valid = 1'b0; io.clr_err = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_start", 64'(io.start_out), 64'd0);
        chk("rst_x",     64'(io.x_out),     64'd0);
        chk("rst_k",     64'(io.k_out),     64'd0);
        chk("rst_cls",   64'(io.cls_out),   64'd0);
        chk("rst_err",   64'(io.err_sticky), 64'd0);
        rst_n = 1'b1;

        // directed normals and reduction boundaries
        send(32'h3F80_0000); send(32'h4000_0000); send(32'h3FA0_0000);
        send(32'h3FE0_0000); send(32'h3FC0_0000); send(32'h3FFF_FFFF);
        send(32'h3F80_0001); send(32'h0080_0000); send(32'h7F7F_FFFF);
        send(32'h3FBF_FFFF);
        drain();
        chk("err_clean", 64'(io.err_sticky), 64'd0);

        for (int i = 0; i < 20; i++)
            send({1'b0, 8'($urandom_range(1, 254)), 23'($urandom)});
        drain();
        chk("err_after_rand", 64'(io.err_sticky), 64'd0);

        // special classes
        send(32'hBF80_0000); send(32'h7FC0_0000); send(32'h7F80_0000);
        send(32'h8000_0000); send(32'h0000_0001); send(32'h8000_0001);
        send(32'hFF80_0000); send(32'hFFC0_0000);
        drain();
        chk("err_set", 64'(io.err_sticky), 64'd1);

        io.clr_err = 1'b1; idle(1); io.clr_err = 1'b0;
        chk("err_clr", 64'(io.err_sticky), 64'd0);

        // clear coinciding with a NaN leaving the pipe
        send(32'h7FC0_0000);
        repeat (3) @(posedge clk); #1;
        chk("nan_emerge", 64'(io.start_out), 64'd1);
        io.clr_err = 1'b1;
        @(posedge clk); #1;
        chk("err_set_wins", 64'(io.err_sticky), 64'd1);
        @(posedge clk); #1;
        io.clr_err = 1'b0;
        chk("err_clr_next", 64'(io.err_sticky), 64'd0);
        drain();

        // reset with three samples in flight
        send(32'h4040_0000); send(32'h3FE0_0000); send(32'h7FC0_0000);
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_x",   64'(io.x_out),   64'd0);
        chk("midrst_cls", 64'(io.cls_out), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("midrst_quiet", 64'(io.start_out), 64'd0);
            idle(1);
        end
        send(32'h4120_0000);
        drain();
        chk("err_after_rst", 64'(io.err_sticky), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ln_range_reduce.md
LN_RANGE_REDUCE -- requirements
Module: ln_range_reduce

Interface
REQ-001 Parameter FLUSH_DENORM, default 1; 1 = subnormal inputs are classified as zero.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 y  input  32  IEEE-754 single operand for ln(y).
REQ-005 in_valid  input  1  y is valid this cycle; one sample per cycle accepted, no backpressure.
REQ-006 clr_err  input  1  clears err_sticky.
REQ-007 x_out  output  32  reduced argument, IEEE single, feeds downstream series core x.
REQ-008 start_out  output  1  feeds downstream core start.
REQ-009 k_out  output  9  signed exponent k, where y = 2^k * (1 + x_out).
REQ-010 cls_out  output  3  class: 0 normal, 1 zero, 2 negative, 3 +inf, 4 NaN.
REQ-011 err_sticky  output  1  set if any accepted sample has cls != 0.

Function
REQ-012 Fixed 4-stage pipeline: S1 unpack/classify, S2 fixed-point reduce, S3 leading-zero count, S4 normalise/pack; outputs registered at S4.
REQ-013 start_out, x_out, k_out and cls_out shall appear exactly 4 cycles after the in_valid cycle; throughput 1/cycle; no bubbles inserted.
REQ-014 Classification priority: NaN (E=255, f!=0) > negative (sign=1, nonzero) > +inf > zero (E=0 and f=0, or E=0 with FLUSH_DENORM=1) > normal.
REQ-015 Any -0.0 input shall be classed zero.
REQ-016 Normal input, f[22]=0 (m<1.5): k = E-127; x = +f*2^-23.
REQ-017 Normal input, f[22]=1 (m>=1.5): k = E-126; x = -(2^23-f)*2^-24.
REQ-018 x_out shall be the exact float of x: if f=0, x_out=32'h00000000; otherwise exponent = 127+p-23 (case 016) or 127+p-24 (case 017), where p is the leading-one index of the operand; mantissa = operand shifted left with the hidden bit dropped.
REQ-019 No rounding is required; the reduction is exact, and |x_out| <= 0.5 always.
REQ-020 For every non-normal class, x_out=0 and k_out=0, and start_out still asserts so that downstream alignment is preserved.
REQ-021 When start_out=0, x_out, k_out and cls_out shall hold 0.
REQ-022 err_sticky shall set in the cycle a non-normal result leaves S4.
REQ-023 err_sticky shall clear on clr_err.
REQ-024 If clr_err is asserted and a set event occurs in the same cycle, set wins.

Reset
REQ-025 With rst_n=0 at a clock edge, all pipeline valid bits, x_out, k_out, cls_out, start_out and err_sticky shall become 0.
REQ-026 Samples in flight when reset is asserted shall be discarded and never emerge.
REQ-027 The first sample accepted after reset deassertion shall emerge 4 cycles later.

Structure
REQ-028 The shared package ln_pkg shall hold the class encodings, the float constants (one, one_half, ...) and the latency constant LN_RR_LAT=4.
REQ-029 A single sub-module, lzc24, shall implement a 24-bit leading-zero counter, used in S3.

Verification
REQ-030 Inputs y=3F800000, 40000000 and 3FA00000 -> 4 cycles later: x_out=00000000/k=0, x_out=00000000/k=1, x_out=3E800000/k=0; all cls=0.
REQ-031 Input y=3FE00000 (1.75) -> x_out=BE000000 (-0.125), k_out=1, cls=0.
REQ-032 Inputs BF800000, 7FC00000, 7F800000 and 80000000 -> cls 2, 4, 3, 1 respectively, x_out=0, start_out asserted, err_sticky=1 after the first of these emerges.
REQ-033 Back-to-back in_valid over 20 random normals -> 20 consecutive start_out pulses; each output matches the reference model, with 2^k*(1+x) == y bit-exact.
REQ-034 Apply rst_n=0 for 1 cycle while 3 samples are in flight -> no start_out for the next 4 cycles; a new sample then emerges after 4 cycles.
REQ-035 Assert clr_err in the same cycle a NaN result emerges -> err_sticky=1; assert clr_err the next cycle -> 0.
